prog_mem_loader: RTL and testbench

- Parallel-programming sequencer directly upstream of the program memory + memory FSM top level.
- Turns one host request (chip erase, write word, read word) into the pin-level sequence: XA/BS1/DATA setup, XTAL1 latch pulses, WR strobe, RDY wait, OE read.
- Raises prog_active so the core holds PC_RD low while programming is in progress.

---
 rtl/prog_mem_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_prog_mem_loader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loader.sv
// Parallel-programming sequencer: converts one host request (erase, write word,
// read word) into the pin-level load/strobe/ready/read sequence for the program
// memory, and flags prog_active while a request is in flight.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         host request handshake (ready only in IDLE)
//   req_op/req_addr/req_wdata   00 erase, 01 write, 10 read, 11 illegal
//   rsp_valid/rsp_rdata/rsp_err one-cycle completion, read data, error flag
//   prog_active                 busy from acceptance through rsp_valid
//   XA/BS1/DATA/XTAL1/WR/OE     memory programming pins (all registered)
//   RDY/Dout                    memory ready and read data
module prog_mem_loader #(
    parameter int unsigned WR_LOW_CYCLES  = 2,
    parameter int unsigned RD_LAT_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [13:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        prog_active,
    output logic [1:0]  XA,
    output logic        BS1,
    output logic [7:0]  DATA,
    output logic        XTAL1,
    output logic        WR,
    output logic        OE,
    input  logic        RDY,
    input  logic [15:0] Dout
);

    localparam int unsigned WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned STB_MAX = (WR_LOW_CYCLES > RD_LAT_CYCLES) ? WR_LOW_CYCLES : RD_LAT_CYCLES;
    localparam int unsigned STB_W   = $clog2(STB_MAX + 1);
    localparam int unsigned CNT_W   = (WAIT_W > STB_W) ? WAIT_W : STB_W;

    localparam logic [1:0] OP_ERASE = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    typedef enum logic [2:0] {
        IDLE, LD_SET, LD_HI, LD_LO, WR_STB, WR_WAIT, RD_OE, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         step_q, step_d;
    logic [1:0]         op_q, op_d;
    logic [13:0]        addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [1:0]  xa_d;
    logic        bs1_d, xtal1_d, wr_d, oe_d;
    logic [7:0]  data_d;
    logic        ready_d, valid_d, err_d, active_d;
    logic [15:0] rdata_d;
    logic [10:0] ld_w;

    // {XA, BS1, DATA} for load number idx of an operation's load list
    function automatic logic [10:0] load_word(input logic [1:0] op, input logic [2:0] idx,
                                              input logic [13:0] addr, input logic [15:0] wdata);
        logic [10:0] w;
        logic [7:0]  cmd;
        cmd = (op == OP_ERASE) ? 8'h80 : ((op == OP_WRITE) ? 8'h10 : 8'h02);
        case (idx)
            3'd0:    w = {2'b10, 1'b0, cmd};
            3'd1:    w = {2'b00, 1'b0, addr[7:0]};
            3'd2:    w = {2'b00, 1'b1, 2'b00, addr[13:8]};
            3'd3:    w = {2'b01, 1'b0, wdata[7:0]};
            3'd4:    w = {2'b01, 1'b1, wdata[15:8]};
            default: w = '0;
        endcase
        return w;
    endfunction

    // Index of the final load in each operation's list
    function automatic logic [2:0] last_step(input logic [1:0] op);
        case (op)
            OP_WRITE: return 3'd4;
            OP_READ:  return 3'd2;
            default:  return 3'd0;
        endcase
    endfunction

    // Next state, latched request and next registered pin values
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rsp_rdata;
        err_d    = 1'b0;
        xa_d     = 2'b00;
        bs1_d    = 1'b0;
        data_d   = 8'h00;
        xtal1_d  = 1'b0;
        wr_d     = 1'b1;
        oe_d     = 1'b1;
        ready_d  = 1'b0;
        valid_d  = 1'b0;
        active_d = 1'b0;
        ld_w     = '0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    step_d  = 3'd0;
                    cnt_d   = '0;
                    if (req_op == OP_ILL) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = LD_SET;
                    end
                end
            end
            LD_SET: state_d = LD_HI;
            LD_HI:  state_d = LD_LO;
            LD_LO: begin
                if (step_q == last_step(op_q)) begin
                    cnt_d   = '0;
                    state_d = (op_q == OP_READ) ? RD_OE : WR_STB;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = LD_SET;
                end
            end
            WR_STB: begin
                if (cnt_q == CNT_W'(WR_LOW_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = WR_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_WAIT: begin
                // cnt_q == 0 is the busy-latency cycle where RDY is not trusted
                if ((cnt_q != '0) && RDY) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RD_OE: begin
                if (cnt_q == CNT_W'(RD_LAT_CYCLES - 1)) begin
                    rdata_d = Dout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pins are decoded from the next state so they register alongside it
        ld_w = load_word(op_d, step_d, addr_d, wdata_d);
        if ((state_d == LD_SET) || (state_d == LD_HI) || (state_d == LD_LO)) begin
            {xa_d, bs1_d, data_d} = ld_w;
        end
        xtal1_d  = (state_d == LD_HI);
        wr_d     = (state_d != WR_STB);
        oe_d     = (state_d != RD_OE);
        ready_d  = (state_d == IDLE);
        valid_d  = (state_d == DONE);
        active_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= 3'd0;
            op_q        <= 2'b00;
            addr_q      <= 14'h0000;
            wdata_q     <= 16'h0000;
            cnt_q       <= '0;
            XA          <= 2'b00;
            BS1         <= 1'b0;
            DATA        <= 8'h00;
            XTAL1       <= 1'b0;
            WR          <= 1'b1;
            OE          <= 1'b1;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 16'h0000;
            rsp_err     <= 1'b0;
            prog_active <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            XA          <= xa_d;
            BS1         <= bs1_d;
            DATA        <= data_d;
            XTAL1       <= xtal1_d;
            WR          <= wr_d;
            OE          <= oe_d;
            req_ready   <= ready_d;
            rsp_valid   <= valid_d;
            rsp_rdata   <= rdata_d;
            rsp_err     <= err_d;
            prog_active <= active_d;
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: a trace-level reference model lists the expected
// pin/response values for every cycle of a request; a table of directed
// requests, hand-written reset sequences and random requests are replayed.
module tb_prog_mem_loader;

    localparam int unsigned WR_LOW = 2;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned TMO    = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [13:0] req_addr = 14'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        prog_active;
    logic [1:0]  XA;
    logic        BS1;
    logic [7:0]  DATA;
    logic        XTAL1;
    logic        WR;
    logic        OE;
    logic        RDY;
    logic [15:0] Dout;

    always #5 clk = ~clk;

    prog_mem_loader #(
        .WR_LOW_CYCLES (WR_LOW),
        .RD_LAT_CYCLES (RD_LAT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .prog_active(prog_active),
        .XA         (XA),
        .BS1        (BS1),
        .DATA       (DATA),
        .XTAL1      (XTAL1),
        .WR         (WR),
        .OE         (OE),
        .RDY        (RDY),
        .Dout       (Dout)
    );

    typedef struct packed {
        logic [1:0]  xa;
        logic        bs1;
        logic [7:0]  data;
        logic        xtal1;
        logic        wr;
        logic        oe;
        logic        ready;
        logic        valid;
        logic        err;
        logic        active;
        logic [15:0] rdata;
    } pin_t;

    typedef struct {
        logic [1:0]  op;
        logic [13:0] addr;
        logic [15:0] wdata;
        int unsigned busy;     // RDY-low cycles after WR release
        logic [15:0] rdval;    // value the memory returns on a read
        logic        exp_err;
        int          exp_lat;  // cycles from acceptance edge to rsp_valid
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    pin_t        exp_q[$];
    logic [15:0] rdata_model = 16'h0000;

    // Memory side: RDY stays low for busy_cfg cycles after WR returns high
    int unsigned busy_cfg = 0;
    logic [15:0] rd_val = 16'h0;
    bit          post_wr = 1'b0;
    int unsigned since_wr = 0;
    int unsigned oe_lo = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_wr  = 1'b0;
            since_wr = 0;
            RDY      = 1'b0;
        end else if (!WR) begin
            post_wr  = 1'b1;
            since_wr = 0;
            RDY      = 1'b0;
        end else if (post_wr) begin
            RDY      = (since_wr >= busy_cfg);
            since_wr = since_wr + 1;
        end else begin
            RDY = 1'b0;
        end
    end

    // Memory side: Dout is only correct on the RD_LAT-th OE-low cycle
    always @(negedge clk) begin
        if (!OE) begin
            oe_lo = oe_lo + 1;
            Dout  = (oe_lo == RD_LAT) ? rd_val : ~rd_val;
        end else begin
            oe_lo = 0;
            Dout  = ~rd_val;
        end
    end

    function automatic pin_t idle_pin(input logic [15:0] rd);
        pin_t p;
        p = '0;
        p.wr    = 1'b1;
        p.oe    = 1'b1;
        p.ready = 1'b1;
        p.rdata = rd;
        return p;
    endfunction

    function automatic pin_t observe();
        pin_t p;
        p.xa     = XA;
        p.bs1    = BS1;
        p.data   = DATA;
        p.xtal1  = XTAL1;
        p.wr     = WR;
        p.oe     = OE;
        p.ready  = req_ready;
        p.valid  = rsp_valid;
        p.err    = rsp_err;
        p.active = prog_active;
        p.rdata  = rsp_rdata;
        return p;
    endfunction

    task automatic chk_pin(input string name, input int cyc, input pin_t got, input pin_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got xa=%b bs1=%b data=%h xtal1=%b wr=%b oe=%b rdy=%b vld=%b err=%b act=%b rdata=%h | required xa=%b bs1=%b data=%h xtal1=%b wr=%b oe=%b rdy=%b vld=%b err=%b act=%b rdata=%h",
                     name, cyc,
                     got.xa, got.bs1, got.data, got.xtal1, got.wr, got.oe, got.ready, got.valid, got.err, got.active, got.rdata,
                     exp.xa, exp.bs1, exp.data, exp.xtal1, exp.wr, exp.oe, exp.ready, exp.valid, exp.err, exp.active, exp.rdata);
        end
    endtask

    task automatic chk_val(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Expected per-cycle trace of one request, starting the cycle after acceptance
    task automatic model_build(input vec_t v);
        pin_t        p;
        logic [10:0] lds[$];
        int unsigned eff;
        int unsigned wait_n;
        logic        err;
        exp_q.delete();
        err = 1'b0;
        p = idle_pin(rdata_model);
        p.ready  = 1'b0;
        p.active = 1'b1;
        if (v.op == 2'b11) begin
            err = 1'b1;
        end else begin
            case (v.op)
                2'b00:   lds.push_back({2'b10, 1'b0, 8'h80});
                2'b01:   lds.push_back({2'b10, 1'b0, 8'h10});
                default: lds.push_back({2'b10, 1'b0, 8'h02});
            endcase
            if (v.op != 2'b00) begin
                lds.push_back({2'b00, 1'b0, v.addr[7:0]});
                lds.push_back({2'b00, 1'b1, 2'b00, v.addr[13:8]});
            end
            if (v.op == 2'b01) begin
                lds.push_back({2'b01, 1'b0, v.wdata[7:0]});
                lds.push_back({2'b01, 1'b1, v.wdata[15:8]});
            end
            foreach (lds[j]) begin
                for (int ph = 0; ph < 3; ph++) begin
                    {p.xa, p.bs1, p.data} = lds[j];
                    p.xtal1 = (ph == 1);
                    exp_q.push_back(p);
                end
            end
            p.xa = 2'b00; p.bs1 = 1'b0; p.data = 8'h00; p.xtal1 = 1'b0;
            if (v.op == 2'b10) begin
                p.oe = 1'b0;
                repeat (RD_LAT) exp_q.push_back(p);
                p.oe = 1'b1;
                rdata_model = v.rdval;
            end else begin
                p.wr = 1'b0;
                repeat (WR_LOW) exp_q.push_back(p);
                p.wr = 1'b1;
                // first post-release cycle never counts as ready
                eff = (v.busy == 0) ? 1 : v.busy;
                if (eff > TMO) begin
                    err    = 1'b1;
                    wait_n = TMO + 1;
                end else begin
                    wait_n = eff + 1;
                end
                repeat (wait_n) exp_q.push_back(p);
            end
        end
        p.valid = 1'b1;
        p.err   = err;
        p.rdata = rdata_model;
        exp_q.push_back(p);
        exp_q.push_back(idle_pin(rdata_model));
    endtask

    // Issue a request at the current negedge and check every cycle of its trace
    task automatic run_txn(input string name, input vec_t v, input bit noisy, input int stop_at,
                           output int lat, output logic err_seen);
        pin_t got;
        model_build(v);
        busy_cfg  = v.busy;
        rd_val    = v.rdval;
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        lat       = 0;
        err_seen  = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                req_valid = noisy;
                req_op    = 2'($urandom);
                req_addr  = 14'($urandom);
                req_wdata = 16'($urandom);
            end
            if (exp_q[i].valid) req_valid = 1'b0;
            got = observe();
            chk_pin(name, i, got, exp_q[i]);
            if (got.valid && lat == 0) begin
                lat      = i + 1;
                err_seen = got.err;
            end
            if (i == stop_at) return;
        end
    endtask

    vec_t tbl[10];

    initial begin
        vec_t v;
        int   lat;
        logic e;

        tbl[0] = '{2'b00, 14'h0000, 16'h0000, 10,         16'h0000, 1'b0, 17};
        tbl[1] = '{2'b01, 14'h0A5C, 16'hBEEF, 3,          16'h0000, 1'b0, 22};
        tbl[2] = '{2'b10, 14'h0A5C, 16'h0000, 0,          16'hBEEF, 1'b0, 12};
        tbl[3] = '{2'b11, 14'h0155, 16'h1111, 0,          16'h5555, 1'b1, 1};
        tbl[4] = '{2'b01, 14'h3FFF, 16'h0000, 0,          16'h0000, 1'b0, 20};
        tbl[5] = '{2'b10, 14'h3FFF, 16'h0000, 0,          16'h1234, 1'b0, 12};
        tbl[6] = '{2'b00, 14'h0000, 16'h0000, TMO,        16'h0000, 1'b0, 4103};
        tbl[7] = '{2'b01, 14'h1111, 16'h2222, 32'hFFFF_FFFF, 16'h0000, 1'b1, 4115};
        tbl[8] = '{2'b10, 14'h2AAA, 16'h0000, 0,          16'hA5A5, 1'b0, 12};
        tbl[9] = '{2'b00, 14'h0000, 16'h0000, 1,          16'h0000, 1'b0, 8};

        // Reset: values while held and after release
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_pin("reset_held", 0, observe(), idle_pin(16'h0000));
        rst_n = 1'b1;
        @(negedge clk);
        chk_pin("reset_released", 0, observe(), idle_pin(16'h0000));

        // Directed table, back to back
        for (int k = 0; k < 10; k++) begin
            run_txn($sformatf("tbl%0d", k), tbl[k], (k % 2) == 1, -1, lat, e);
            chk_val($sformatf("tbl%0d_latency", k), lat, tbl[k].exp_lat);
            chk_val($sformatf("tbl%0d_err", k), int'(e), int'(tbl[k].exp_err));
        end

        // Reset during the fourth load of a write, while XTAL1 is high
        v = '{2'b01, 14'h1234, 16'hC0DE, 5, 16'h0000, 1'b0, 0};
        run_txn("midrst_write", v, 1'b0, 10, lat, e);
        rst_n = 1'b0;
        #1;
        rdata_model = 16'h0000;
        chk_pin("midrst_async", 0, observe(), idle_pin(16'h0000));
        @(negedge clk);
        @(negedge clk);
        chk_pin("midrst_held", 0, observe(), idle_pin(16'h0000));
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_pin("midrst_after", c, observe(), idle_pin(16'h0000));
        end
        v = '{2'b10, 14'h1234, 16'h0000, 0, 16'h6789, 1'b0, 12};
        run_txn("midrst_read", v, 1'b0, -1, lat, e);
        chk_val("midrst_read_latency", lat, 12);

        // Random requests against the trace model
        for (int r = 0; r < 30; r++) begin
            v.op    = 2'($urandom_range(0, 3));
            v.addr  = 14'($urandom);
            v.wdata = 16'($urandom);
            v.busy  = $urandom_range(0, 12);
            v.rdval = 16'($urandom);
            v.exp_err = 1'b0;
            v.exp_lat = 0;
            run_txn($sformatf("rand%0d", r), v, 1'($urandom_range(0, 1)), -1, lat, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
